// File: rtl/mem_port_arbiter_if.sv
// Core-side imem/dmem request ports and the shared single-port memory bus.
// The arbiter uses the slave modport; the core/memory side uses master.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  imem_req_i;
    logic [ADDR_WIDTH-1:0] imem_addr_i;
    logic [DATA_WIDTH-1:0] imem_rdata_o;
    logic                  imem_ack_o;

    logic                  dmem_req_i;
    logic                  dmem_we_i;
    logic [ADDR_WIDTH-1:0] dmem_addr_i;
    logic [DATA_WIDTH-1:0] dmem_wdata_i;
    logic [DATA_WIDTH-1:0] dmem_rdata_o;
    logic                  dmem_ack_o;

    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  imem_req_i, imem_addr_i,
        output imem_rdata_o, imem_ack_o,
        input  dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        output dmem_rdata_o, dmem_ack_o,
        output mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output imem_req_i, imem_addr_i,
        input  imem_rdata_o, imem_ack_o,
        output dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        input  dmem_rdata_o, dmem_ack_o,
        input  mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of the core's imem/dmem ports onto one memory port,
// with programmable wait states and a registered one-cycle ack.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WAIT_W     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WAIT_W-1:0] wait_i,
    mem_port_arbiter_if.slave bus,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                state_q;
    logic [WAIT_W-1:0]     cnt_q;
    logic                  last_dmem_q;
    logic                  gnt_dmem_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  mem_we_q;
    logic                  imem_ack_q;
    logic                  dmem_ack_q;
    logic [DATA_WIDTH-1:0] imem_rdata_q;
    logic [DATA_WIDTH-1:0] dmem_rdata_q;
    logic                  pick_dmem;

    // dmem wins when alone, or on contention when imem was served last.
    assign pick_dmem = bus.dmem_req_i & (~bus.imem_req_i | ~last_dmem_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_dmem_q  <= 1'b0;
            gnt_dmem_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_we_q     <= 1'b0;
            imem_ack_q   <= 1'b0;
            dmem_ack_q   <= 1'b0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
        end else begin
            mem_we_q   <= 1'b0;
            imem_ack_q <= 1'b0;
            dmem_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.imem_req_i || bus.dmem_req_i) begin
                        gnt_dmem_q <= pick_dmem;
                        addr_q     <= pick_dmem ? bus.dmem_addr_i : bus.imem_addr_i;
                        wdata_q    <= pick_dmem ? bus.dmem_wdata_i : '0;
                        we_q       <= pick_dmem & bus.dmem_we_i;
                        cnt_q      <= wait_i;
                        // Write strobe is registered, so arm it one cycle early.
                        mem_we_q   <= pick_dmem & bus.dmem_we_i & (wait_i == '0);
                        state_q    <= StAccess;
                    end
                end
                StAccess: begin
                    if (cnt_q != '0) begin
                        cnt_q    <= cnt_q - WAIT_W'(1);
                        mem_we_q <= we_q & (cnt_q == WAIT_W'(1));
                    end else begin
                        if (gnt_dmem_q) begin
                            dmem_ack_q   <= 1'b1;
                            dmem_rdata_q <= we_q ? '0 : bus.mem_rdata_i;
                        end else begin
                            imem_ack_q   <= 1'b1;
                            imem_rdata_q <= bus.mem_rdata_i;
                        end
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    last_dmem_q <= gnt_dmem_q;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.imem_ack_o   = imem_ack_q;
    assign bus.imem_rdata_o = imem_rdata_q;
    assign bus.dmem_ack_o   = dmem_ack_q;
    assign bus.dmem_rdata_o = dmem_rdata_q;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wdata_o  = wdata_q;
    assign busy_o           = (state_q != StIdle);

endmodule
